// File: rtl/blink_led_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | blink_led_pkg : shared clock constants and helpers for blink_led |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
package blink_led_pkg;

  localparam int CLK_HZ              = 25_000_000;
  localparam int DEFAULT_HALF_SECOND = CLK_HZ / 2;
  localparam int LED_COUNT_W         = 3;

  typedef logic [LED_COUNT_W-1:0] led_count_t;

  // A period of 1 still needs a 1-bit counter so the compare stays legal.
  function automatic int cnt_width(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/blink_led_tick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | blink_led_tick : wrap counter, one-cycle tick every HALF_SECOND  |
// | Revision       : 1.0                                             |
// +------------------------------------------------------------------+
module blink_led_tick
  import blink_led_pkg::*;
#(
  parameter int HALF_SECOND = DEFAULT_HALF_SECOND
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int               CNT_W = cnt_width(HALF_SECOND);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(HALF_SECOND - 1);

  logic [CNT_W-1:0] cnt_q = '0;
  logic [CNT_W-1:0] cnt_d;

  // Tick is high during the last count, so the consumer acts on the wrapping edge.
  always_comb begin
    tick_o = (cnt_q == LAST);
    cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/blink_led.sv
`default_nettype none
// +------------------------------------------------------------------+
// | blink_led : 1 Hz heartbeat on o_LED_1; BLINK_LED_COUNT_EN adds a |
// |             binary half-period count on o_LED_2..o_LED_4         |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
module blink_led
  import blink_led_pkg::*;
#(
  parameter int HALF_SECOND = DEFAULT_HALF_SECOND
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  output logic o_LED_1,
  output logic o_LED_2,
  output logic o_LED_3,
  output logic o_LED_4
);

`ifdef BLINK_LED_COUNT_EN
  localparam int TOG_W = $bits(led_count_t);
`else
  localparam int TOG_W = 1;
`endif

  logic             tick;
  logic [TOG_W-1:0] tog_q = '0;
  logic [TOG_W-1:0] tog_d;

  blink_led_tick #(
    .HALF_SECOND(HALF_SECOND)
  ) u_tick (
    .clk_i (i_Clk),
    .rst_ni(i_Rst_L),
    .tick_o(tick)
  );

  always_comb begin
    tog_d = tick ? tog_q + TOG_W'(1) : tog_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tog_q <= '0;
    end else begin
      tog_q <= tog_d;
    end
  end

  // Bit 0 of the half-period count is the blink itself.
  assign o_LED_1 = tog_q[0];

`ifdef BLINK_LED_COUNT_EN
  assign o_LED_2 = tog_q[0];
  assign o_LED_3 = tog_q[1];
  assign o_LED_4 = tog_q[2];
`else
  assign o_LED_2 = 1'b0;
  assign o_LED_3 = 1'b0;
  assign o_LED_4 = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_blink_led.sv
`default_nettype none
// Bench for blink_led: main instance (HALF_SECOND=50), a HALF_SECOND=1
// instance sharing reset, and a never-reset instance.
module tb_blink_led;

  localparam int H = 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rst_hi = 1'b1;

  logic m1, m2, m3, m4;
  logic f1, f2, f3, f4;
  logic u1, u2, u3, u4;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;
  int edges_u  = 0;
  int last_tog = 0;
  logic prev_led1 = 1'b0;
  logic [11:0] sb[$];

  always #20 clk = ~clk;

  blink_led #(.HALF_SECOND(H)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .o_LED_1(m1), .o_LED_2(m2), .o_LED_3(m3), .o_LED_4(m4)
  );

  blink_led #(.HALF_SECOND(1)) dut_fast (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .o_LED_1(f1), .o_LED_2(f2), .o_LED_3(f3), .o_LED_4(f4)
  );

  blink_led #(.HALF_SECOND(H)) dut_norst (
    .i_Clk(clk), .i_Rst_L(rst_hi),
    .o_LED_1(u1), .o_LED_2(u2), .o_LED_3(u3), .o_LED_4(u4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected {LED4,LED3,LED2,LED1} after e edges of a free-running blinker of period h.
  function automatic logic [3:0] exp_leds(input int e, input int h);
    logic [2:0] c;
    c = 3'((e / h) % 8);
`ifdef BLINK_LED_COUNT_EN
    return {c[2], c[1], c[0], c[0]};
`else
    return {3'b000, c[0]};
`endif
  endfunction

  task automatic step();
    logic [11:0] e;
    @(posedge clk);
    edges_u++;
    if (rst_n) edges++;
    e[3:0]  = rst_n ? exp_leds(edges, H) : 4'b0000;
    e[7:4]  = rst_n ? exp_leds(edges, 1) : 4'b0000;
    e[11:8] = exp_leds(edges_u, H);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check("main_leds", {28'b0, m4, m3, m2, m1}, {28'b0, e[3:0]});
    check("fast_leds", {28'b0, f4, f3, f2, f1}, {28'b0, e[7:4]});
    check("norst_leds", {28'b0, u4, u3, u2, u1}, {28'b0, e[11:8]});
`ifdef BLINK_LED_COUNT_EN
    check("led2_eq_led1", {31'b0, m2}, {31'b0, m1});
`endif
    if (m1 !== prev_led1) begin
      check("toggle_gap", edges - last_tog, H);
      last_tog  = edges;
      prev_led1 = m1;
    end
  endtask

  initial begin
    #1;
    check("norst_init_led1", {31'b0, u1}, 32'd0);
    check("main_rst_leds", {28'b0, m4, m3, m2, m1}, 32'd0);

    repeat (3) step();
    rst_n = 1'b1;
    edges = 0;

    // Steady toggling, then reset in the middle of a count.
    repeat (130) step();
    #10;
    rst_n = 1'b0;
    #1;
    check("async_rst_main", {28'b0, m4, m3, m2, m1}, 32'd0);
    check("async_rst_fast", {28'b0, f4, f3, f2, f1}, 32'd0);
    edges     = 0;
    last_tog  = 0;
    prev_led1 = 1'b0;
    repeat (2) step();
    @(negedge clk);
    edges_u++;
    rst_n = 1'b1;

    // Long run: full 8-step count wrap, or 10 toggles with idle count LEDs.
    repeat (520) step();
    check("final_toggles", last_tog, 500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
